// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV opcodes, immediate format enum and opcode-to-format decode
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} imm_fmt_e;

  function automatic imm_fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      OP_OP:                    return FMT_R;
      default:                  return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// rtl/imm_range_check.sv - combinational check that an immediate fits its format slot
module imm_range_check
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  imm_fmt_e        fmt_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            ok_o
);

  // imm == sext(imm[n:0]) exactly when bits [XLEN-1:n] are all equal
  logic sx11, sx12, sx20, sx31;
  assign sx11 = (&imm_i[XLEN-1:11]) | ~(|imm_i[XLEN-1:11]);
  assign sx12 = (&imm_i[XLEN-1:12]) | ~(|imm_i[XLEN-1:12]);
  assign sx20 = (&imm_i[XLEN-1:20]) | ~(|imm_i[XLEN-1:20]);
  assign sx31 = (&imm_i[XLEN-1:31]) | ~(|imm_i[XLEN-1:31]);

  always_comb begin
    ok_o = 1'b1;
    case (fmt_i)
      FMT_I, FMT_S: ok_o = sx11;
      FMT_B:        ok_o = sx12 & ~imm_i[0];
      FMT_J:        ok_o = sx20 & ~imm_i[0];
      FMT_U:        ok_o = sx31 & ~(|imm_i[11:0]);
      default:      ok_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - 2-stage valid/ready RV instruction packer
// Optional immediate range/alignment checking under IMM_RANGE_CHECK_EN.
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [XLEN-1:0]      in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic        s1_valid_q;
  imm_fmt_e    s1_fmt_q;
  logic [6:0]  s1_op_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_f7_q;
  logic [31:0] s1_imm_q;
  logic        s1_rng_ok_q;

  logic                 s2_valid_q;
  logic [31:0]          s2_instr_q;
  logic                 s2_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  imm_fmt_e    in_fmt;
  logic        rng_ok_d;
  logic        s2_load;
  logic [31:0] instr_d;
  logic        err_d;
  logic        unused_imm_hi;

  assign in_fmt        = fmt_of(in_opcode);
  // Upper immediate bits only matter to the range check; the packer never sees them.
  assign unused_imm_hi = ^in_imm[XLEN-1:32];

`ifdef IMM_RANGE_CHECK_EN
  imm_range_check #(.XLEN(XLEN)) u_imm_range_check (
    .fmt_i (in_fmt),
    .imm_i (in_imm),
    .ok_o  (rng_ok_d)
  );
`else
  assign rng_ok_d = 1'b1;
`endif

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= FMT_BAD;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_f3_q     <= '0;
      s1_f7_q     <= '0;
      s1_imm_q    <= '0;
      s1_rng_ok_q <= 1'b1;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_fmt_q    <= in_fmt;
        s1_op_q     <= in_opcode;
        s1_rd_q     <= in_rd;
        s1_rs1_q    <= in_rs1;
        s1_rs2_q    <= in_rs2;
        s1_f3_q     <= in_funct3;
        s1_f7_q     <= in_funct7;
        s1_imm_q    <= in_imm[31:0];
        s1_rng_ok_q <= rng_ok_d;
      end
    end
  end

  always_comb begin
    instr_d = '0;
    case (s1_fmt_q)
      FMT_R: instr_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_I: instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_S: instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      FMT_B: instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                        s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      FMT_U: instr_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      FMT_J: instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                        s1_rd_q, s1_op_q};
      default: instr_d = '0;
    endcase
    err_d = (s1_fmt_q == FMT_BAD) || !s1_rng_ok_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= instr_d;
        s2_err_q   <= err_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + CNT_ONE;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_cnt_q;

endmodule
